// File: rtl/branch_lut_loader.sv
// rtl/branch_lut_loader.sv - programmable branch-target table with byte-stream loader
// Purpose: a header byte N followed by N address bytes fills table entries 0..N-1;
//          the fetch stage reads any entry combinationally, zero-extended.
// Ports:
//   CLK, reset            clock, synchronous active-high reset
//   load_start            pulse; starts a load when not busy
//   in_valid, in_data     byte stream (header, then addresses)
//   in_ready              byte accepted this cycle when in_valid is also high
//   idx, targ_addr        asynchronous table lookup
//   busy, done, err       loader status (done/err sticky until next accepted start)
//   count                 entries written by the current or last load
module branch_lut_loader #(
   parameter int ENTRIES = 32,
   parameter int ADDR_W  = 8,
   parameter int TARG_W  = 16
) (
   input  logic                       CLK,
   input  logic                       reset,
   input  logic                       load_start,
   input  logic                       in_valid,
   input  logic [ADDR_W-1:0]          in_data,
   output logic                       in_ready,
   input  logic [$clog2(ENTRIES)-1:0] idx,
   output logic [TARG_W-1:0]          targ_addr,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [$clog2(ENTRIES):0]   count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(ENTRIES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  n_q,     n_d;
   logic [ADDR_W-1:0] table_q [ENTRIES];
   logic [ADDR_W-1:0] table_d [ENTRIES];
   logic              accept;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         n_q     <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         n_q     <= n_d;
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= table_d[i];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      n_d      = n_q;
      table_d  = table_q;
      in_ready = (state_q == S_HDR) || (state_q == S_DATA);
      busy     = in_ready;
      done     = (state_q == S_DONE);
      err      = (state_q == S_ERR);
      accept   = in_valid && in_ready;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (load_start) begin
               state_d = S_HDR;
               count_d = '0;
            end
         end
         S_HDR: begin
            if (accept) begin
               if (in_data == '0) begin
                  state_d = S_DONE;
               end else if (in_data > MAX_N) begin
                  state_d = S_ERR;
               end else begin
                  // N <= ENTRIES here, so the low CNT_W bits hold it exactly
                  n_d     = in_data[CNT_W-1:0];
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               // count < N <= ENTRIES in this state, so the low bits are a valid index
               table_d[count_q[IDX_W-1:0]] = in_data;
               count_d = count_q + CNT_W'(1);
               if (count_d == n_q) begin
                  state_d = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign count     = count_q;
   assign targ_addr = {{(TARG_W-ADDR_W){1'b0}}, table_q[idx]};

endmodule
